// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: result-select codes, default widths
// and the load-alignment rule.
package wb_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned RW_DEF = 5;

  // MemtoReg result-select codes; any code above MR_LHU behaves as MR_ALU.
  typedef enum logic [3:0] {
    MR_ALU = 4'd0,
    MR_LW  = 4'd1,
    MR_LB  = 4'd2,
    MR_LBU = 4'd3,
    MR_LH  = 4'd4,
    MR_LHU = 4'd5
  } memToReg_e;

  function automatic logic isMisaligned(input logic [3:0] code, input logic [1:0] addr);
    logic mis;
    mis = 1'b0;
    case (code)
      MR_LW:        mis = (addr != 2'd0);
      MR_LH, MR_LHU: mis = addr[0];
      default:      mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/writeback_load_align.sv
// Per-lane big-endian byte/half extraction with sign/zero extension and
// misaligned-access detection.
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [3:0]    memToReg,
  input  logic [DW-1:0] readData,
  input  logic [DW-1:0] aluout,
  output logic [DW-1:0] result,
  output logic          misalign
);

  logic [31:0] word;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    word = readData[31:0];
    byteSel = '0;
    case (aluout[1:0])
      2'd0:    byteSel = word[31:24];
      2'd1:    byteSel = word[23:16];
      2'd2:    byteSel = word[15:8];
      default: byteSel = word[7:0];
    endcase
    halfSel = aluout[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    result = aluout;
    case (memToReg)
      MR_LW: begin
        result = '0;
        result[31:0] = word;
      end
      MR_LB: begin
        result = {DW{byteSel[7]}};
        result[7:0] = byteSel;
      end
      MR_LBU: begin
        result = '0;
        result[7:0] = byteSel;
      end
      MR_LH: begin
        result = {DW{halfSel[15]}};
        result[15:0] = halfSel;
      end
      MR_LHU: begin
        result = '0;
        result[15:0] = halfSel;
      end
      default: result = aluout;
    endcase
  end

  assign misalign = isMisaligned(memToReg, aluout[1:0]);

endmodule

// File: rtl/writeback.sv
// Dual-lane M->W pipeline register and result selection.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback
  import wb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallW,
  input  logic          flushW,
  input  logic [3:0]    MemtoRegM1,
  input  logic [3:0]    MemtoRegM2,
  input  logic          RegWriteM1,
  input  logic          RegWriteM2,
  input  logic          jumpM1,
  input  logic          jumpM2,
  input  logic [DW-1:0] ReadDataM1,
  input  logic [DW-1:0] ReadDataM2,
  input  logic [DW-1:0] aluoutM1,
  input  logic [DW-1:0] aluoutM2,
  input  logic [DW-1:0] PCPlus8M,
  input  logic [RW-1:0] writeregM1,
  input  logic [RW-1:0] writeregM2,
  output logic          RegWriteW1,
  output logic          RegWriteW2,
  output logic [RW-1:0] writeregW1,
  output logic [RW-1:0] writeregW2,
  output logic [DW-1:0] resultW1,
  output logic [DW-1:0] resultW2,
  output logic          misalignW
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]   retiredW
`endif
);

  localparam logic [DW-1:0] LINK_STEP = DW'(4);

  logic [3:0]    memToRegR1, memToRegR2;
  logic          regWriteR1, regWriteR2;
  logic          jumpR1, jumpR2;
  logic [DW-1:0] readDataR1, readDataR2;
  logic [DW-1:0] aluoutR1, aluoutR2;
  logic [DW-1:0] pcPlus8R;
  logic [RW-1:0] writeregR1, writeregR2;
  logic          misSticky;

  logic [DW-1:0] loadData1, loadData2;
  logic          loadMis1, loadMis2;
  logic          mis1, mis2;
  logic          write1, write2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      memToRegR1 <= '0;
      memToRegR2 <= '0;
      regWriteR1 <= 1'b0;
      regWriteR2 <= 1'b0;
      jumpR1     <= 1'b0;
      jumpR2     <= 1'b0;
      readDataR1 <= '0;
      readDataR2 <= '0;
      aluoutR1   <= '0;
      aluoutR2   <= '0;
      pcPlus8R   <= '0;
      writeregR1 <= '0;
      writeregR2 <= '0;
    end else if (flushW) begin
      memToRegR1 <= '0;
      memToRegR2 <= '0;
      regWriteR1 <= 1'b0;
      regWriteR2 <= 1'b0;
      jumpR1     <= 1'b0;
      jumpR2     <= 1'b0;
    end else if (!stallW) begin
      memToRegR1 <= MemtoRegM1;
      memToRegR2 <= MemtoRegM2;
      regWriteR1 <= RegWriteM1;
      regWriteR2 <= RegWriteM2;
      jumpR1     <= jumpM1;
      jumpR2     <= jumpM2;
      readDataR1 <= ReadDataM1;
      readDataR2 <= ReadDataM2;
      aluoutR1   <= aluoutM1;
      aluoutR2   <= aluoutM2;
      pcPlus8R   <= PCPlus8M;
      writeregR1 <= writeregM1;
      writeregR2 <= writeregM2;
    end
  end

  // The flag shows combinationally in the cycle the bad load sits in W,
  // and the sticky register keeps it up afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      misSticky <= 1'b0;
    end else if (mis1 || mis2) begin
      misSticky <= 1'b1;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [1:0] retireInc;

  always_comb begin
    retireInc = 2'(regWriteR1 | jumpR1) + 2'(regWriteR2 | jumpR2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      retiredW <= '0;
    end else if (!stallW) begin
      retiredW <= retiredW + 32'(retireInc);
    end
  end
`endif

  load_align #(.DW(DW)) uAlign1 (
    .memToReg (memToRegR1),
    .readData (readDataR1),
    .aluout   (aluoutR1),
    .result   (loadData1),
    .misalign (loadMis1)
  );

  load_align #(.DW(DW)) uAlign2 (
    .memToReg (memToRegR2),
    .readData (readDataR2),
    .aluout   (aluoutR2),
    .result   (loadData2),
    .misalign (loadMis2)
  );

  // A jump overrides MemtoReg, so its lane is never a load and cannot misalign.
  always_comb begin
    mis1   = loadMis1 & ~jumpR1;
    mis2   = loadMis2 & ~jumpR2;
    write2 = regWriteR2 && (writeregR2 != '0) && !mis2;
    write1 = regWriteR1 && (writeregR1 != '0) && !mis1 &&
             !(write2 && (writeregR2 == writeregR1));
  end

  assign RegWriteW1 = write1;
  assign RegWriteW2 = write2;
  assign writeregW1 = writeregR1;
  assign writeregW2 = writeregR2;
  assign resultW1   = jumpR1 ? pcPlus8R : loadData1;
  assign resultW2   = jumpR2 ? (pcPlus8R + LINK_STEP) : loadData2;
  assign misalignW  = misSticky | mis1 | mis2;

endmodule
